// File: rtl/prodos_hdd_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : prodos_hdd_multi_if
//  Description : Host-side bundle of the ProDOS multi-unit block device.
//                Carries the block request handshake (sector, unit index,
//                read/write request, ack), per-unit mount/protect status
//                and the host port of the shared 512-byte sector buffer.
//                master = slot card, slave = host block store.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prodos_hdd_multi_if #(
    parameter int NUM_UNITS  = 2,
    parameter int BLOCK_BITS = 16
);
    logic [BLOCK_BITS-1:0] sector;
    logic [1:0]            unit_idx;
    logic                  hdd_read;
    logic                  hdd_write;
    logic                  hdd_ack;
    logic [NUM_UNITS-1:0]  hdd_mounted;
    logic [NUM_UNITS-1:0]  hdd_protect;
    logic [8:0]            ram_addr;
    logic [7:0]            ram_di;
    logic [7:0]            ram_do;
    logic                  ram_we;

    modport master (
        output sector, unit_idx, hdd_read, hdd_write, ram_do,
        input  hdd_ack, hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we
    );

    modport slave (
        input  sector, unit_idx, hdd_read, hdd_write, ram_do,
        output hdd_ack, hdd_mounted, hdd_protect, ram_addr, ram_di, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/prodos_hdd_multi.sv
`default_nettype none
// ============================================================================
//  Module      : prodos_hdd_multi
//  Description : Multi-unit ProDOS block-device slot card with a non-halting
//                transfer engine. CPU side decodes C0n0-C0nB registers and the
//                CnXX firmware window; host side receives READ/WRITE requests
//                and shares a 512-byte dual-ported sector buffer.
//  Ports       : CLK_14M, RESET      clock, synchronous active-high reset
//                phi0, IO_SELECT,    CPU bus phase and selects
//                DEVICE_SELECT
//                A, RD, D_IN, D_OUT  CPU address / direction / data
//                rom_dout            firmware byte for the CnXX window
//                hif (master)        host request handshake + sector buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module prodos_hdd_multi #(
    parameter int NUM_UNITS   = 2,
    parameter int SLOT        = 7,
    parameter int BLOCK_BITS  = 16,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  wire logic        CLK_14M,
    input  wire logic        RESET,
    input  wire logic        phi0,
    input  wire logic        IO_SELECT,
    input  wire logic        DEVICE_SELECT,
    input  wire logic [15:0] A,
    input  wire logic        RD,
    input  wire logic [7:0]  D_IN,
    output logic      [7:0]  D_OUT,
    input  wire logic [7:0]  rom_dout,
    prodos_hdd_multi_if.master hif
);

    localparam logic [2:0] c_slot_pri = 3'(SLOT);
    localparam logic [2:0] c_slot_sec = 3'(SLOT - 1);
    localparam int         c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_RD = 2'd1,
        ST_REQ_WR = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [7:0]  r_cmd, r_unit, r_mem_lo, r_mem_hi, r_blk_lo, r_blk_hi, r_errcode;
    logic        r_err;
    logic [8:0]  r_sec_addr;
    logic        r_dev_seen, r_dev_d, r_data_pend;
    logic [BLOCK_BITS-1:0] r_sector;
    logic [1:0]  r_unit_idx;
    logic [c_tmo_w-1:0] r_tmo;
    logic [7:0]  r_buf [0:511];

    logic        w_acc, w_rd_acc, w_reg_wr_ok, w_busy, w_exec, w_fall;
    logic [3:0]  w_reg;
    logic [7:0]  w_blk_ext, w_exec_code, w_rd_data;
    logic [23:0] w_blk;
    logic [3:0]  w_mnt4, w_prot4;
    logic [1:0]  w_idx;
    logic        w_pri, w_sec, w_valid, w_prot;
    logic        w_go_rd, w_go_wr, w_start, w_tmo_expire, w_done_ok;
    logic        w_cpu_buf_we;
    logic        w_unused_addr;

    assign w_unused_addr = ^A[15:4];

    // One access per select: act only on the first phi0 cycle of DEVICE_SELECT.
    assign w_acc        = DEVICE_SELECT & phi0 & ~r_dev_seen;
    assign w_rd_acc     = w_acc & RD;
    assign w_reg        = A[3:0];
    assign w_busy       = (r_state != ST_IDLE);
    assign w_reg_wr_ok  = w_acc & ~RD & ~w_busy;
    assign w_exec       = w_rd_acc & (w_reg == 4'h0);
    assign w_fall       = r_dev_d & ~DEVICE_SELECT;
    assign w_cpu_buf_we = w_reg_wr_ok & (w_reg == 4'h8);
    assign w_start      = w_exec & (w_go_rd | w_go_wr);
    assign w_blk        = {w_blk_ext, r_blk_hi, r_blk_lo};

    // Upper block byte only exists when the block number is wider than 16 bits.
    generate
        if (BLOCK_BITS > 16) begin : g_blk_ext_on
            logic [7:0] r_blk_ext;
            always_ff @(posedge CLK_14M) begin
                if (RESET)
                    r_blk_ext <= 8'h00;
                else if (w_reg_wr_ok && w_reg == 4'hB)
                    r_blk_ext <= D_IN;
            end
            assign w_blk_ext = r_blk_ext;
        end else begin : g_blk_ext_off
            assign w_blk_ext = 8'h00;
        end
    endgenerate

    // Unit decode: primary slot serves units 0/1, slot-1 serves units 2/3.
    always_comb begin
        w_mnt4  = '0;
        w_prot4 = '0;
        w_mnt4[NUM_UNITS-1:0]  = hif.hdd_mounted;
        w_prot4[NUM_UNITS-1:0] = hif.hdd_protect;
        w_pri   = (r_unit[6:4] == c_slot_pri);
        w_sec   = (NUM_UNITS > 2) && (r_unit[6:4] == c_slot_sec);
        w_idx   = w_pri ? {1'b0, r_unit[7]} : {1'b1, r_unit[7]};
        w_valid = (w_pri | w_sec) && (int'(w_idx) < NUM_UNITS) && w_mnt4[w_idx];
        w_prot  = w_prot4[w_idx];
    end

    // EXEC result code and command launch decision.
    always_comb begin
        w_exec_code = 8'h01;
        w_go_rd     = 1'b0;
        w_go_wr     = 1'b0;
        if (w_busy) begin
            w_exec_code = 8'h80;
        end else begin
            case (r_cmd)
                8'h00: w_exec_code = w_valid ? 8'h00 : 8'h28;
                8'h03: w_exec_code = !w_valid ? 8'h28 : (w_prot ? 8'h2B : 8'h00);
                8'h01: begin
                    if (!w_valid) begin
                        w_exec_code = 8'h28;
                    end else begin
                        w_exec_code = 8'h80;
                        w_go_rd     = 1'b1;
                    end
                end
                8'h02: begin
                    if (!w_valid) begin
                        w_exec_code = 8'h28;
                    end else if (w_prot) begin
                        w_exec_code = 8'h2B;
                    end else begin
                        w_exec_code = 8'h80;
                        w_go_wr     = 1'b1;
                    end
                end
                default: w_exec_code = 8'h01;
            endcase
        end
    end

    // CPU read mux.
    always_comb begin
        w_rd_data = 8'hFF;
        case (w_reg)
            4'h0: w_rd_data = w_exec_code;
            4'h1: w_rd_data = {w_busy, 6'b0, r_err};
            4'h2: w_rd_data = r_cmd;
            4'h3: w_rd_data = r_unit;
            4'h4: w_rd_data = r_mem_lo;
            4'h5: w_rd_data = r_mem_hi;
            4'h6: w_rd_data = r_blk_lo;
            4'h7: w_rd_data = r_blk_hi;
            4'h8: w_rd_data = w_busy ? 8'hFF : r_buf[r_sec_addr];
            4'h9: w_rd_data = r_errcode;
            4'hB: w_rd_data = w_blk_ext;
            default: w_rd_data = 8'hFF;
        endcase
    end

    // Transfer FSM: next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmo_expire = 1'b0;
        w_done_ok    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_exec && w_go_rd)
                    w_state_nxt = ST_REQ_RD;
                else if (w_exec && w_go_wr)
                    w_state_nxt = ST_REQ_WR;
            end
            ST_REQ_RD, ST_REQ_WR: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (hif.hdd_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_done_ok   = 1'b1;
                end else if (r_tmo == c_tmo_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_tmo_expire = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // CPU-side registers, status and request latches.
    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            r_cmd       <= 8'h00;
            r_unit      <= 8'h00;
            r_mem_lo    <= 8'h00;
            r_mem_hi    <= 8'h00;
            r_blk_lo    <= 8'h00;
            r_blk_hi    <= 8'h00;
            r_errcode   <= 8'h00;
            r_err       <= 1'b0;
            r_sec_addr  <= 9'd0;
            r_dev_seen  <= 1'b0;
            r_dev_d     <= 1'b0;
            r_data_pend <= 1'b0;
            r_sector    <= '0;
            r_unit_idx  <= 2'd0;
            r_tmo       <= '0;
            D_OUT       <= 8'hFF;
        end else begin
            r_dev_d <= DEVICE_SELECT;
            if (!DEVICE_SELECT)
                r_dev_seen <= 1'b0;
            else if (phi0)
                r_dev_seen <= 1'b1;

            if (IO_SELECT && RD)
                D_OUT <= rom_dout;
            else if (w_rd_acc)
                D_OUT <= w_rd_data;
            else if (!(DEVICE_SELECT && RD))
                D_OUT <= 8'hFF;

            if (w_reg_wr_ok) begin
                case (w_reg)
                    4'h2: r_cmd    <= D_IN;
                    4'h3: r_unit   <= D_IN;
                    4'h4: r_mem_lo <= D_IN;
                    4'h5: r_mem_hi <= D_IN;
                    4'h6: r_blk_lo <= D_IN;
                    4'h7: r_blk_hi <= D_IN;
                    default: ;
                endcase
            end

            // The buffer pointer advances when the CPU releases the select
            // after a DATA access, so a single access never double-steps.
            if (w_acc && w_reg == 4'h8 && !w_busy)
                r_data_pend <= 1'b1;
            else if (w_fall)
                r_data_pend <= 1'b0;

            if (w_start || (w_reg_wr_ok && w_reg == 4'h2))
                r_sec_addr <= 9'd0;
            else if (w_fall && r_data_pend && !w_busy)
                r_sec_addr <= r_sec_addr + 9'd1;

            if (w_start) begin
                r_sector   <= w_blk[BLOCK_BITS-1:0];
                r_unit_idx <= w_idx;
            end

            if (r_state == ST_IDLE)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + c_tmo_w'(1);

            if (w_exec && !w_busy) begin
                if (w_exec_code == 8'h00 || w_exec_code == 8'h80) begin
                    r_err <= 1'b0;
                end else begin
                    r_err     <= 1'b1;
                    r_errcode <= w_exec_code;
                end
            end
            if (w_done_ok)
                r_err <= 1'b0;
            if (w_tmo_expire) begin
                r_err     <= 1'b1;
                r_errcode <= 8'h27;
            end
        end
    end

    // Sector buffer: not reset. Host write takes priority on an address clash.
    always_ff @(posedge CLK_14M) begin
        if (w_cpu_buf_we && !(hif.ram_we && hif.ram_addr == r_sec_addr))
            r_buf[r_sec_addr] <= D_IN;
        if (hif.ram_we)
            r_buf[hif.ram_addr] <= hif.ram_di;
        hif.ram_do <= r_buf[hif.ram_addr];
    end

    assign hif.hdd_read  = (r_state == ST_REQ_RD);
    assign hif.hdd_write = (r_state == ST_REQ_WR);
    assign hif.sector    = r_sector;
    assign hif.unit_idx  = r_unit_idx;

endmodule
`default_nettype wire

// File: tb/tb_prodos_hdd_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prodos_hdd_multi
//  Description : Self-checking bench for prodos_hdd_multi: a register vector
//                table followed by hand-written transfer, buffer, timeout,
//                reset and firmware-window sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prodos_hdd_multi;

    localparam int c_units = 4;
    localparam int c_bbits = 24;
    localparam int c_tmo   = 40;

    logic        CLK_14M = 1'b0;
    logic        RESET = 1'b1;
    logic        phi0 = 1'b0;
    logic        IO_SELECT = 1'b0;
    logic        DEVICE_SELECT = 1'b0;
    logic [15:0] A = 16'hC0F0;
    logic        RD = 1'b1;
    logic [7:0]  D_IN = 8'h00;
    logic [7:0]  D_OUT;
    logic [7:0]  rom_dout = 8'h00;

    prodos_hdd_multi_if #(.NUM_UNITS(c_units), .BLOCK_BITS(c_bbits)) hif ();

    prodos_hdd_multi #(
        .NUM_UNITS(c_units), .SLOT(7), .BLOCK_BITS(c_bbits), .TIMEOUT_CYC(c_tmo)
    ) dut (
        .CLK_14M(CLK_14M), .RESET(RESET), .phi0(phi0), .IO_SELECT(IO_SELECT),
        .DEVICE_SELECT(DEVICE_SELECT), .A(A), .RD(RD), .D_IN(D_IN),
        .D_OUT(D_OUT), .rom_dout(rom_dout), .hif(hif.master)
    );

    always #5 CLK_14M = ~CLK_14M;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] r;
        logic       rd;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [0:35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One CPU register access; returns the byte seen on D_OUT after the strobe.
    task automatic cpu_acc(input logic [3:0] r, input logic rd, input logic [7:0] wd,
                           output logic [7:0] rdat);
        @(negedge CLK_14M);
        A = 16'hC0F0 | {12'h0, r};
        RD = rd; D_IN = wd; DEVICE_SELECT = 1'b1; phi0 = 1'b1;
        @(negedge CLK_14M);
        rdat = D_OUT;
        DEVICE_SELECT = 1'b0; phi0 = 1'b0; RD = 1'b1;
        @(negedge CLK_14M);
    endtask

    task automatic cpu_wr(input logic [3:0] r, input logic [7:0] wd);
        logic [7:0] dummy;
        cpu_acc(r, 1'b0, wd, dummy);
    endtask

    task automatic host_rd(input logic [8:0] a, output logic [7:0] rdat);
        @(negedge CLK_14M);
        hif.ram_addr = a;
        @(negedge CLK_14M);
        rdat = hif.ram_do;
    endtask

    task automatic ack_pulse();
        @(negedge CLK_14M);
        hif.hdd_ack = 1'b1;
        @(negedge CLK_14M);
        hif.hdd_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] rv;

        hif.hdd_ack     = 1'b0;
        hif.hdd_mounted = 4'b1111;
        hif.hdd_protect = 4'b0010;
        hif.ram_addr    = 9'd0;
        hif.ram_di      = 8'h00;
        hif.ram_we      = 1'b0;

        vt[0]  = '{4'h1, 1'b1, 8'h00, 8'h00};
        vt[1]  = '{4'h9, 1'b1, 8'h00, 8'h00};
        vt[2]  = '{4'h3, 1'b0, 8'h70, 8'h00};
        vt[3]  = '{4'h3, 1'b1, 8'h00, 8'h70};
        vt[4]  = '{4'h2, 1'b0, 8'h00, 8'h00};
        vt[5]  = '{4'h0, 1'b1, 8'h00, 8'h00};
        vt[6]  = '{4'h3, 1'b0, 8'h50, 8'h00};
        vt[7]  = '{4'h0, 1'b1, 8'h00, 8'h28};
        vt[8]  = '{4'h1, 1'b1, 8'h00, 8'h01};
        vt[9]  = '{4'h9, 1'b1, 8'h00, 8'h28};
        vt[10] = '{4'h3, 1'b0, 8'hE0, 8'h00};
        vt[11] = '{4'h0, 1'b1, 8'h00, 8'h00};
        vt[12] = '{4'h1, 1'b1, 8'h00, 8'h00};
        vt[13] = '{4'h2, 1'b0, 8'h03, 8'h00};
        vt[14] = '{4'h3, 1'b0, 8'hF0, 8'h00};
        vt[15] = '{4'h0, 1'b1, 8'h00, 8'h2B};
        vt[16] = '{4'h9, 1'b1, 8'h00, 8'h2B};
        vt[17] = '{4'h3, 1'b0, 8'h70, 8'h00};
        vt[18] = '{4'h0, 1'b1, 8'h00, 8'h00};
        vt[19] = '{4'h2, 1'b0, 8'h07, 8'h00};
        vt[20] = '{4'h0, 1'b1, 8'h00, 8'h01};
        vt[21] = '{4'h9, 1'b1, 8'h00, 8'h01};
        vt[22] = '{4'h2, 1'b0, 8'h02, 8'h00};
        vt[23] = '{4'h3, 1'b0, 8'hF0, 8'h00};
        vt[24] = '{4'h0, 1'b1, 8'h00, 8'h2B};
        vt[25] = '{4'h4, 1'b0, 8'h12, 8'h00};
        vt[26] = '{4'h4, 1'b1, 8'h00, 8'h12};
        vt[27] = '{4'h5, 1'b0, 8'h34, 8'h00};
        vt[28] = '{4'h5, 1'b1, 8'h00, 8'h34};
        vt[29] = '{4'hB, 1'b0, 8'hAB, 8'h00};
        vt[30] = '{4'hB, 1'b1, 8'h00, 8'hAB};
        vt[31] = '{4'h6, 1'b0, 8'h5A, 8'h00};
        vt[32] = '{4'h6, 1'b1, 8'h00, 8'h5A};
        vt[33] = '{4'hA, 1'b1, 8'h00, 8'hFF};
        vt[34] = '{4'h2, 1'b1, 8'h00, 8'h02};
        vt[35] = '{4'h3, 1'b1, 8'h00, 8'hF0};

        // Reset state
        repeat (3) @(negedge CLK_14M);
        check("reset D_OUT", {24'h0, D_OUT}, 32'hFF);
        check("reset hdd_read", {31'h0, hif.hdd_read}, 32'h0);
        check("reset hdd_write", {31'h0, hif.hdd_write}, 32'h0);
        RESET = 1'b0;

        // Register / EXEC decode table
        for (int i = 0; i < 36; i++) begin
            cpu_acc(vt[i].r, vt[i].rd, vt[i].wd, rv);
            if (vt[i].rd)
                check($sformatf("vec %0d reg %0h", i, vt[i].r), {24'h0, rv}, {24'h0, vt[i].exp});
        end
        check("protected write no request", {31'h0, hif.hdd_write}, 32'h0);

        // READ on unit 0x70, block 0x000123, busy behaviour, ack
        cpu_wr(4'h2, 8'h01);
        cpu_wr(4'h3, 8'h70);
        cpu_wr(4'h6, 8'h23);
        cpu_wr(4'h7, 8'h01);
        cpu_wr(4'hB, 8'h00);
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("read exec", {24'h0, rv}, 32'h80);
        check("hdd_read high", {31'h0, hif.hdd_read}, 32'h1);
        check("hdd_write low", {31'h0, hif.hdd_write}, 32'h0);
        check("sector", {8'h0, hif.sector}, 32'h000123);
        check("unit_idx 0", {30'h0, hif.unit_idx}, 32'h0);
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("busy exec", {24'h0, rv}, 32'h80);
        cpu_acc(4'h1, 1'b1, 8'h00, rv);
        check("busy status", {24'h0, rv}, 32'h80);
        cpu_wr(4'h2, 8'h05);
        cpu_wr(4'h6, 8'h99);
        cpu_acc(4'h8, 1'b1, 8'h00, rv);
        check("busy data read", {24'h0, rv}, 32'hFF);
        ack_pulse();
        check("read dropped after ack", {31'h0, hif.hdd_read}, 32'h0);
        cpu_acc(4'h1, 1'b1, 8'h00, rv);
        check("status after ack", {24'h0, rv}, 32'h00);
        cpu_acc(4'h2, 1'b1, 8'h00, rv);
        check("cmd unchanged while busy", {24'h0, rv}, 32'h01);
        cpu_acc(4'h6, 1'b1, 8'h00, rv);
        check("blk unchanged while busy", {24'h0, rv}, 32'h23);

        // Unit 0xE0 maps to index 3 on the secondary slot
        cpu_wr(4'h3, 8'hE0);
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("E0 exec", {24'h0, rv}, 32'h80);
        check("unit_idx 3", {30'h0, hif.unit_idx}, 32'h3);
        ack_pulse();
        hif.hdd_mounted = 4'b0111;
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("unmounted unit", {24'h0, rv}, 32'h28);
        check("unmounted no request", {31'h0, hif.hdd_read}, 32'h0);
        hif.hdd_mounted = 4'b1111;

        // WRITE with ack on the very last allowed cycle: success
        cpu_wr(4'h3, 8'h70);
        cpu_wr(4'h2, 8'h02);
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("write exec", {24'h0, rv}, 32'h80);
        repeat (c_tmo - 2) @(negedge CLK_14M);
        check("write held to last cycle", {31'h0, hif.hdd_write}, 32'h1);
        hif.hdd_ack = 1'b1;
        @(negedge CLK_14M);
        hif.hdd_ack = 1'b0;
        check("write dropped on late ack", {31'h0, hif.hdd_write}, 32'h0);
        cpu_acc(4'h1, 1'b1, 8'h00, rv);
        check("late ack status", {24'h0, rv}, 32'h00);

        // WRITE with no ack: timeout
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("timeout exec", {24'h0, rv}, 32'h80);
        repeat (c_tmo - 2) @(negedge CLK_14M);
        check("write before timeout", {31'h0, hif.hdd_write}, 32'h1);
        @(negedge CLK_14M);
        check("write dropped on timeout", {31'h0, hif.hdd_write}, 32'h0);
        cpu_acc(4'h1, 1'b1, 8'h00, rv);
        check("timeout status", {24'h0, rv}, 32'h01);
        cpu_acc(4'h9, 1'b1, 8'h00, rv);
        check("timeout errcode", {24'h0, rv}, 32'h27);

        // 515 DATA writes: pointer wraps at 512
        cpu_wr(4'h2, 8'h00);
        for (int i = 0; i < 515; i++)
            cpu_wr(4'h8, 8'(i));
        host_rd(9'd0, rv);   check("buf[0]", {24'h0, rv}, 32'h00);
        host_rd(9'd1, rv);   check("buf[1]", {24'h0, rv}, 32'h01);
        host_rd(9'd2, rv);   check("buf[2]", {24'h0, rv}, 32'h02);
        host_rd(9'd3, rv);   check("buf[3]", {24'h0, rv}, 32'h03);
        host_rd(9'd511, rv); check("buf[511]", {24'h0, rv}, 32'hFF);
        cpu_wr(4'h2, 8'h00);
        cpu_acc(4'h8, 1'b1, 8'h00, rv);
        check("cpu data read 0", {24'h0, rv}, 32'h00);
        cpu_acc(4'h8, 1'b1, 8'h00, rv);
        check("cpu data read 1", {24'h0, rv}, 32'h01);

        // Same-cycle host and CPU write to address 5: host wins
        cpu_wr(4'h2, 8'h00);
        repeat (5) cpu_acc(4'h8, 1'b1, 8'h00, rv);
        @(negedge CLK_14M);
        A = 16'hC0F8; RD = 1'b0; D_IN = 8'h11; DEVICE_SELECT = 1'b1; phi0 = 1'b1;
        hif.ram_we = 1'b1; hif.ram_addr = 9'd5; hif.ram_di = 8'h99;
        @(negedge CLK_14M);
        hif.ram_we = 1'b0; DEVICE_SELECT = 1'b0; phi0 = 1'b0; RD = 1'b1;
        @(negedge CLK_14M);
        host_rd(9'd5, rv); check("collision host wins", {24'h0, rv}, 32'h99);
        host_rd(9'd6, rv); check("neighbour untouched", {24'h0, rv}, 32'h06);

        // RESET during REQ_WR drops the request next cycle, buffer survives
        cpu_wr(4'h3, 8'h70);
        cpu_wr(4'h2, 8'h02);
        cpu_acc(4'h0, 1'b1, 8'h00, rv);
        check("pre-reset write exec", {24'h0, rv}, 32'h80);
        RESET = 1'b1;
        @(negedge CLK_14M);
        check("reset drops write", {31'h0, hif.hdd_write}, 32'h0);
        RESET = 1'b0;
        cpu_acc(4'h2, 1'b1, 8'h00, rv);
        check("cmd cleared by reset", {24'h0, rv}, 32'h00);
        host_rd(9'd3, rv); check("buffer kept over reset", {24'h0, rv}, 32'h03);

        // Firmware window
        @(negedge CLK_14M);
        IO_SELECT = 1'b1; RD = 1'b1; rom_dout = 8'h5A; A = 16'hC742;
        @(negedge CLK_14M);
        check("rom byte", {24'h0, D_OUT}, 32'h5A);
        IO_SELECT = 1'b0;
        @(negedge CLK_14M);
        check("idle D_OUT", {24'h0, D_OUT}, 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
